// File: rtl/dekatron_step_sequencer_pkg.sv
// Shared types and helpers for the dekatron step sequencer.
// Optional feature macro: DEKATRON_POS_TRACK_EN (shortest-path helper used only when it is defined).
package dekatron_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PHA,
        S_PHB,
        S_REST
    } dek_seq_state_t;

    typedef struct packed {
        logic        dec;
        logic [15:0] steps;
    } dek_move_t;

    function automatic int dek_step_period(input int pulse_w, input int rest_w);
        return 2 * pulse_w + rest_w;
    endfunction

    // Ties (d == n/2) resolve to the increment direction.
    function automatic dek_move_t dek_shortest(input int unsigned pos,
                                               input int unsigned tgt,
                                               input int unsigned n);
        int unsigned d;
        dek_move_t   m;
        d = (tgt + n - pos) % n;
        if (d <= n / 2) begin
            m.dec   = 1'b0;
            m.steps = 16'(d);
        end else begin
            m.dec   = 1'b1;
            m.steps = 16'(n - d);
        end
        return m;
    endfunction

endpackage

// File: rtl/dekatron_step_sequencer_if.sv
// Request/status bundle between DekatronPC control and the step sequencer.
// Optional feature macro: DEKATRON_POS_TRACK_EN adds Goto/Target/Position.
interface dekatron_step_sequencer_if #(
    parameter int CNT_W = 4
`ifdef DEKATRON_POS_TRACK_EN
    , parameter int POS_W = 4
`endif
);
    logic             Req;
    logic             Dec;
    logic [CNT_W-1:0] Steps;
    logic             Abort;
    logic             Ack;
    logic             Busy;
    logic             Done;
    logic [1:0]       PulsesOut;
`ifdef DEKATRON_POS_TRACK_EN
    logic             Goto;
    logic [POS_W-1:0] Target;
    logic [POS_W-1:0] Position;

    modport master (output Req, Dec, Steps, Abort, Goto, Target,
                    input  Ack, Busy, Done, PulsesOut, Position);
    modport slave  (input  Req, Dec, Steps, Abort, Goto, Target,
                    output Ack, Busy, Done, PulsesOut, Position);
`else
    modport master (output Req, Dec, Steps, Abort,
                    input  Ack, Busy, Done, PulsesOut);
    modport slave  (input  Req, Dec, Steps, Abort,
                    output Ack, Busy, Done, PulsesOut);
`endif
endinterface

// File: rtl/dekatron_phase_timer.sv
// Loadable down-counter timing PHA, PHB and REST; expire marks the last cycle of a phase.
module dekatron_phase_timer #(
    parameter int W = 3
) (
    input  logic         hsClk,
    input  logic         Rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] cnt;

    always_ff @(posedge hsClk) begin
        if (!Rst_n)          cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - W'(1);
    end

    assign expire = (cnt == '0);
endmodule

// File: rtl/dekatron_step_sequencer.sv
// Emits a requested number of two-phase guide-pulse pairs with Req/Ack, Busy/Done and Abort.
// Optional feature macro: DEKATRON_POS_TRACK_EN enables cathode position tracking and Goto.
module dekatron_step_sequencer
    import dekatron_pkg::*;
#(
    parameter int PULSE_W = 3,
    parameter int REST_W  = 4,
    parameter int CNT_W   = 4,
    parameter int DEK_N   = 10
) (
    input logic                      hsClk,
    input logic                      Rst_n,
    dekatron_step_sequencer_if.slave bus
);
    localparam int POS_W = $clog2(DEK_N);
    // Wide enough for either a relative request or a half-ring Goto move.
    localparam int REM_W = (CNT_W > POS_W + 1) ? CNT_W : POS_W + 1;
    localparam int MAX_W = (PULSE_W > REST_W) ? PULSE_W : REST_W;
    localparam int TW    = $clog2(MAX_W + 1);

    dek_seq_state_t state, state_nxt;
    logic [REM_W-1:0] rem, rem_nxt;
    logic             dir, dir_nxt;
    logic             abort_flag, abort_nxt;
    logic             ack, ack_nxt, done, done_nxt, busy, busy_nxt;
    logic [1:0]       pulses, pulses_nxt;
    logic             t_load, t_exp;
    logic [TW-1:0]    t_val;
`ifdef DEKATRON_POS_TRACK_EN
    logic [POS_W-1:0] pos, pos_nxt;
    dek_move_t        mv;
`endif

    dekatron_phase_timer #(.W(TW)) u_timer (
        .hsClk    (hsClk),
        .Rst_n    (Rst_n),
        .load     (t_load),
        .load_val (t_val),
        .expire   (t_exp)
    );

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        dir_nxt   = dir;
        abort_nxt = abort_flag | bus.Abort;
        ack_nxt   = 1'b0;
        done_nxt  = 1'b0;
        t_load    = 1'b0;
        t_val     = TW'(PULSE_W - 1);
`ifdef DEKATRON_POS_TRACK_EN
        pos_nxt   = pos;
        mv        = dek_shortest(32'(pos), 32'(bus.Target), DEK_N);
`endif
        case (state)
            S_IDLE: begin
                abort_nxt = 1'b0;
`ifdef DEKATRON_POS_TRACK_EN
                if (bus.Goto) begin
                    ack_nxt = 1'b1;
                    if (mv.steps == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_PHA;
                        t_load    = 1'b1;
                        rem_nxt   = REM_W'(mv.steps);
                        dir_nxt   = mv.dec;
                    end
                end else
`endif
                if (bus.Req) begin
                    ack_nxt = 1'b1;
                    if (bus.Steps == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_PHA;
                        t_load    = 1'b1;
                        rem_nxt   = REM_W'(bus.Steps);
                        dir_nxt   = bus.Dec;
                    end
                end
            end
            S_PHA: if (t_exp) begin
                state_nxt = S_PHB;
                t_load    = 1'b1;
            end
            S_PHB: if (t_exp) begin
                state_nxt = S_REST;
                t_load    = 1'b1;
                t_val     = TW'(REST_W - 1);
            end
            S_REST: if (t_exp) begin
                rem_nxt = rem - REM_W'(1);
`ifdef DEKATRON_POS_TRACK_EN
                if (dir) pos_nxt = (pos == '0) ? POS_W'(DEK_N - 1) : pos - POS_W'(1);
                else     pos_nxt = (pos == POS_W'(DEK_N - 1)) ? '0 : pos + POS_W'(1);
`endif
                if (rem == REM_W'(1) || abort_nxt) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = S_PHA;
                    t_load    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so decode from the state being entered.
        busy_nxt = (state_nxt != S_IDLE);
        case (state_nxt)
            S_PHA:   pulses_nxt = dir_nxt ? 2'b01 : 2'b10;
            S_PHB:   pulses_nxt = dir_nxt ? 2'b10 : 2'b01;
            default: pulses_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge hsClk) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            rem        <= '0;
            dir        <= 1'b0;
            abort_flag <= 1'b0;
            ack        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            pulses     <= 2'b00;
`ifdef DEKATRON_POS_TRACK_EN
            pos        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            rem        <= rem_nxt;
            dir        <= dir_nxt;
            abort_flag <= abort_nxt;
            ack        <= ack_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
            pulses     <= pulses_nxt;
`ifdef DEKATRON_POS_TRACK_EN
            pos        <= pos_nxt;
`endif
        end
    end

    assign bus.Ack       = ack;
    assign bus.Done      = done;
    assign bus.Busy      = busy;
    assign bus.PulsesOut = pulses;
`ifdef DEKATRON_POS_TRACK_EN
    assign bus.Position  = pos;
`endif
endmodule
